// File: rtl/ram_pkg.sv
// Shared types and helpers for the 1R1W clearable RAM: lane count, clear FSM
// states and the byte-lane merge used by both the array write and the read bypass.
package ram_pkg;

    localparam int MAX_DATA = 256;
    localparam int MAX_NBE  = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic int nbe(input int data_w, input int byte_w);
        return (data_w + byte_w - 1) / byte_w;
    endfunction

    // Lane i covers bits [i*byte_w +: byte_w]; the top lane may be partial.
    function automatic logic [MAX_DATA-1:0] merge_be(
        input logic [MAX_DATA-1:0] old_w,
        input logic [MAX_DATA-1:0] new_w,
        input logic [MAX_NBE-1:0]  be,
        input int                  byte_w
    );
        logic [MAX_DATA-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_DATA; i++) begin
            if (((i / byte_w) < MAX_NBE) && be[i / byte_w]) begin
                res[i] = new_w[i];
            end else begin
                res[i] = old_w[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_2p_core.sv
// Plain 1R1W storage array: per-lane write, registered read that returns the
// pre-write content when both ports hit the same entry.
module ram_2p_core
    import ram_pkg::*;
#(
    parameter int DATA  = 72,
    parameter int ADDR  = 9,
    parameter int DEPTH = 2**ADDR,
    parameter int BYTE  = 8,
    parameter int NBE   = nbe(DATA, BYTE)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            we,
    input  logic [ADDR-1:0] waddr,
    input  logic [NBE-1:0]  wbe,
    input  logic [DATA-1:0] wdata,
    input  logic            re,
    input  logic [ADDR-1:0] raddr,
    output logic [DATA-1:0] rdata
);

    logic [DATA-1:0]     mem_q [DEPTH];
    logic [DATA-1:0]     rdata_q;
    logic [DATA-1:0]     rdata_d;
    logic [MAX_DATA-1:0] wr_word_wide_s;
    logic                unused_wide_s;

    assign wr_word_wide_s = merge_be(MAX_DATA'(mem_q[waddr]), MAX_DATA'(wdata),
                                     MAX_NBE'(wbe), BYTE);
    assign unused_wide_s  = ^wr_word_wide_s[MAX_DATA-1:DATA];

    // Next read-register value
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Array write; storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wr_word_wide_s[DATA-1:0];
        end
    end

    // Read register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= {DATA{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_2p_clr.sv
// 1R1W RAM with byte enables, same-address write bypass, a hardware clear
// engine (after reset or on request) and an optional extra read stage.
module ram_2p_clr
    import ram_pkg::*;
#(
    parameter int              DATA       = 72,
    parameter int              ADDR       = 9,
    parameter int              DEPTH      = 2**ADDR,
    parameter int              BYTE       = 8,
    parameter int              NBE        = nbe(DATA, BYTE),
    parameter int              PIPELINE   = 0,
    parameter int              CLR_ON_RST = 1,
    parameter logic [DATA-1:0] CLR_VAL    = {DATA{1'b0}},
    parameter int              WR_BYPASS  = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr_req,
    output logic            clr_busy,
    input  logic            rd_en,
    input  logic [ADDR-1:0] rd_addr,
    output logic [DATA-1:0] rd_data,
    output logic            rd_valid,
    input  logic            wr_en,
    input  logic [ADDR-1:0] wr_addr,
    input  logic [NBE-1:0]  wr_be,
    input  logic [DATA-1:0] wr_data,
    output logic            wr_ready
);

    localparam state_e          RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR-1:0] LAST_IDX  = ADDR'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR-1:0]     cnt_q, cnt_d;
    logic                valid1_q, valid1_d;
    logic                oor_q, oor_d;
    logic [NBE-1:0]      byp_be_q, byp_be_d;
    logic [DATA-1:0]     byp_data_q, byp_data_d;

    logic                rd_in_range_s, wr_in_range_s;
    logic                rd_acc_s, wr_acc_s, clearing_s;
    logic                core_we_s;
    logic [ADDR-1:0]     core_waddr_s;
    logic [NBE-1:0]      core_wbe_s;
    logic [DATA-1:0]     core_wdata_s;
    logic [DATA-1:0]     core_rdata_s;
    logic [MAX_DATA-1:0] merge_wide_s;
    logic [DATA-1:0]     data1_s;
    logic                unused_wide_s;

    generate
        if (DEPTH < (2**ADDR)) begin : g_partial
            assign rd_in_range_s = (rd_addr < ADDR'(DEPTH));
            assign wr_in_range_s = (wr_addr < ADDR'(DEPTH));
        end else begin : g_full
            assign rd_in_range_s = 1'b1;
            assign wr_in_range_s = 1'b1;
        end
    endgenerate

    assign clearing_s = (state_q == ST_CLEAR);
    assign rd_acc_s   = !clearing_s && rd_en;
    assign wr_acc_s   = !clearing_s && wr_en && wr_in_range_s && (wr_be != {NBE{1'b0}});

    // The clear engine owns the write port while active
    assign core_we_s    = clearing_s || wr_acc_s;
    assign core_waddr_s = clearing_s ? cnt_q : wr_addr;
    assign core_wbe_s   = clearing_s ? {NBE{1'b1}} : wr_be;
    assign core_wdata_s = clearing_s ? CLR_VAL : wr_data;

    ram_2p_core #(
        .DATA  (DATA),
        .ADDR  (ADDR),
        .DEPTH (DEPTH),
        .BYTE  (BYTE),
        .NBE   (NBE)
    ) u_core (
        .clk   (clk),
        .rstn  (rstn),
        .we    (core_we_s),
        .waddr (core_waddr_s),
        .wbe   (core_wbe_s),
        .wdata (core_wdata_s),
        .re    (rd_acc_s && rd_in_range_s),
        .raddr (rd_addr),
        .rdata (core_rdata_s)
    );

    // Clear FSM next state and sweep counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = {ADDR{1'b0}};
                end else begin
                    cnt_d   = cnt_q + ADDR'(1'b1);
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = {ADDR{1'b0}};
            end
        endcase
    end

    // Capture bypass lanes and out-of-range flag alongside each accepted read
    always_comb begin
        valid1_d   = rd_acc_s;
        oor_d      = oor_q;
        byp_be_d   = byp_be_q;
        byp_data_d = byp_data_q;
        if (rd_acc_s) begin
            oor_d      = !rd_in_range_s;
            byp_data_d = wr_data;
            if ((WR_BYPASS != 0) && wr_acc_s && (rd_addr == wr_addr)) begin
                byp_be_d = wr_be;
            end else begin
                byp_be_d = {NBE{1'b0}};
            end
        end else begin
            valid1_d = 1'b0;
        end
    end

    // FSM and first read-stage registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RST_STATE;
            cnt_q      <= {ADDR{1'b0}};
            valid1_q   <= 1'b0;
            oor_q      <= 1'b0;
            byp_be_q   <= {NBE{1'b0}};
            byp_data_q <= {DATA{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid1_q   <= valid1_d;
            oor_q      <= oor_d;
            byp_be_q   <= byp_be_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign merge_wide_s  = merge_be(MAX_DATA'(core_rdata_s), MAX_DATA'(byp_data_q),
                                    MAX_NBE'(byp_be_q), BYTE);
    assign unused_wide_s = ^merge_wide_s[MAX_DATA-1:DATA];
    assign data1_s       = oor_q ? CLR_VAL : merge_wide_s[DATA-1:0];

    generate
        if (PIPELINE != 0) begin : g_pipe
            logic            valid2_q, valid2_d;
            logic [DATA-1:0] data2_q, data2_d;

            // Second read stage, loads only when the first stage completes a read
            always_comb begin
                valid2_d = valid1_q;
                data2_d  = data2_q;
                if (valid1_q) begin
                    data2_d = data1_s;
                end else begin
                    data2_d = data2_q;
                end
            end

            // Second read-stage registers
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    valid2_q <= 1'b0;
                    data2_q  <= {DATA{1'b0}};
                end else begin
                    valid2_q <= valid2_d;
                    data2_q  <= data2_d;
                end
            end

            assign rd_data  = data2_q;
            assign rd_valid = valid2_q;
        end else begin : g_nopipe
            assign rd_data  = data1_s;
            assign rd_valid = valid1_q;
        end
    endgenerate

    assign clr_busy = (state_q == ST_CLEAR);
    assign wr_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_ram_2p_clr.sv
// Bench for ram_2p_clr: a default instance (1-cycle read, bypass on) and a
// PIPELINE=1 / WR_BYPASS=0 instance driven together against an array model.
module tb_ram_2p_clr;

    localparam int DATA  = 72;
    localparam int ADDR  = 9;
    localparam int DEPTH = 512;
    localparam int NBE   = 9;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            clr_req = 1'b0;
    logic            rd_en = 1'b0;
    logic            wr_en = 1'b0;
    logic [ADDR-1:0] rd_addr = '0;
    logic [ADDR-1:0] wr_addr = '0;
    logic [NBE-1:0]  wr_be = '0;
    logic [DATA-1:0] wr_data = '0;

    logic [DATA-1:0] rd_data_a, rd_data_b;
    logic            rd_valid_a, rd_valid_b;
    logic            clr_busy_a, clr_busy_b;
    logic            wr_ready_a, wr_ready_b;

    int errors = 0;
    int checks = 0;

    logic [DATA-1:0] ref_mem [DEPTH];
    int              busy_left;
    logic [DATA-1:0] exp_a_data, exp_b_data, pend_b_d;
    logic            pend_b_v;

    always #5 clk = ~clk;

    ram_2p_clr u_a (
        .clk(clk), .rstn(rstn), .clr_req(clr_req), .clr_busy(clr_busy_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_ready(wr_ready_a)
    );

    ram_2p_clr #(.PIPELINE(1), .WR_BYPASS(0)) u_b (
        .clk(clk), .rstn(rstn), .clr_req(clr_req), .clr_busy(clr_busy_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .wr_ready(wr_ready_b)
    );

    task automatic chk(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (ref_mem[k]) ref_mem[k] = '0;
        busy_left  = DEPTH;
        exp_a_data = '0;
        exp_b_data = '0;
        pend_b_v   = 1'b0;
        pend_b_d   = '0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_data_a", rd_data_a, '0);
        chk("rst_rd_valid_a", DATA'(rd_valid_a), '0);
        chk("rst_busy_a", DATA'(clr_busy_a), DATA'(1));
        chk("rst_ready_a", DATA'(wr_ready_a), '0);
        chk("rst_rd_data_b", rd_data_b, '0);
        chk("rst_rd_valid_b", DATA'(rd_valid_b), '0);
        chk("rst_busy_b", DATA'(clr_busy_b), DATA'(1));
    endtask

    task automatic idle_in();
        rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
        wr_be = '0;
    endtask

    // Apply the currently driven inputs for one clock and check both instances.
    task automatic cycle();
        logic            idle, rd_ok;
        logic [DATA-1:0] old_w, byp_w;
        idle  = (busy_left == 0);
        rd_ok = idle && rd_en;
        old_w = ref_mem[rd_addr];
        byp_w = old_w;
        if (idle && wr_en && (wr_addr == rd_addr))
            for (int i = 0; i < NBE; i++) if (wr_be[i]) byp_w[i*8 +: 8] = wr_data[i*8 +: 8];
        if (idle && wr_en)
            for (int i = 0; i < NBE; i++) if (wr_be[i]) ref_mem[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
        if (idle && clr_req) begin
            busy_left = DEPTH;
            foreach (ref_mem[k]) ref_mem[k] = '0;
        end else if (!idle) begin
            busy_left--;
        end
        @(posedge clk);
        #1;
        if (rd_ok) exp_a_data = byp_w;
        chk("rd_valid_a", DATA'(rd_valid_a), DATA'(rd_ok));
        chk("rd_data_a", rd_data_a, exp_a_data);
        if (pend_b_v) exp_b_data = pend_b_d;
        chk("rd_valid_b", DATA'(rd_valid_b), DATA'(pend_b_v));
        chk("rd_data_b", rd_data_b, exp_b_data);
        pend_b_v = rd_ok;
        pend_b_d = old_w;
        chk("clr_busy_a", DATA'(clr_busy_a), DATA'(busy_left != 0));
        chk("wr_ready_b", DATA'(wr_ready_b), DATA'(busy_left == 0));
    endtask

    task automatic rd(input int a);
        idle_in(); rd_en = 1'b1; rd_addr = ADDR'(a); cycle();
    endtask

    task automatic wr(input int a, input logic [NBE-1:0] be, input logic [DATA-1:0] d);
        idle_in(); wr_en = 1'b1; wr_addr = ADDR'(a); wr_be = be; wr_data = d; cycle();
    endtask

    task automatic rand_in(input int amax);
        rd_en   = 1'($urandom_range(0, 1));
        wr_en   = 1'($urandom_range(0, 1));
        rd_addr = ADDR'($urandom_range(0, amax));
        wr_addr = ADDR'($urandom_range(0, amax));
        wr_be   = NBE'($urandom);
        wr_data = {8'($urandom), $urandom, $urandom};
    endtask

    initial begin
        int busy_cnt_a, busy_cnt_b;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rstn = 1'b1;

        // Power-on clear with ignored traffic
        for (int c = 0; c < DEPTH + 2; c++) begin
            if (busy_left != 0) rand_in(DEPTH - 1); else idle_in();
            clr_req = 1'b0;
            cycle();
        end
        rd(0); rd(255); rd(511); idle_in(); cycle();
        chk("post_clear_rd511", rd_data_a, '0);

        // Lane-0-only overwrite
        wr(5, '1, '1);
        wr(5, 9'h001, '0);
        rd(5); idle_in(); cycle();
        chk("lane0_clear", rd_data_a, {{64{1'b1}}, 8'h00});

        // Same-cycle collision on entry 7
        wr(7, '1, 72'h11_2233_4455_6677_8899);
        idle_in();
        rd_en = 1'b1; rd_addr = ADDR'(7);
        wr_en = 1'b1; wr_addr = ADDR'(7); wr_be = '1; wr_data = 72'hA5_A5A5_A5A5_A5A5_A5A5;
        cycle();
        idle_in(); cycle();
        chk("bypass_a", rd_data_a, 72'hA5_A5A5_A5A5_A5A5_A5A5);
        chk("nobypass_b", rd_data_b, 72'h11_2233_4455_6677_8899);

        // Pipelined back-to-back reads then hold
        wr(1, '1, 72'h01); wr(2, '1, 72'h02); wr(3, '1, 72'h03);
        rd(1); rd(2); rd(3);
        idle_in(); repeat (3) cycle();
        chk("pipe_hold_b", rd_data_b, 72'h03);

        // Randomized traffic with frequent collisions
        for (int c = 0; c < 400; c++) begin
            rand_in((c % 4 == 0) ? DEPTH - 1 : 15);
            clr_req = 1'b0;
            cycle();
        end
        for (int a = 0; a < 16; a++) rd(a);

        // Requested clear with writes attempted throughout; read collides with the request
        idle_in(); clr_req = 1'b1; rd_en = 1'b1; rd_addr = ADDR'(5); cycle();
        for (int c = 0; c < DEPTH + 2; c++) begin
            rand_in(15);
            clr_req = 1'($urandom_range(0, 1));
            if (busy_left == 0) begin wr_en = 1'b0; clr_req = 1'b0; end
            cycle();
        end
        for (int a = 0; a < 8; a++) rd(a);
        rd(511);

        // Reset in the middle of a clear at count 100
        idle_in(); clr_req = 1'b1; cycle();
        idle_in();
        repeat (100) cycle();
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        busy_cnt_a = 0;
        busy_cnt_b = 0;
        for (int c = 0; c < DEPTH + 4; c++) begin
            idle_in();
            cycle();
            if (clr_busy_a) busy_cnt_a++;
            if (clr_busy_b) busy_cnt_b++;
        end
        chk("restart_len_a", DATA'(busy_cnt_a), DATA'(DEPTH - 1));
        chk("restart_len_b", DATA'(busy_cnt_b), DATA'(DEPTH - 1));
        rd(100); rd(0); idle_in(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
